mc_controller_hs: RTL and testbench
===================================

// Module: mc_controller_hs
// PURPOSE
//  Next-gen multicycle RV32I control unit: FSM, ALU decode and PC-enable logic.
//  Adds a memory req/ready handshake with wait states and a TRAP state for illegal encodings.
//  Adds optional shift ops and retired-instruction/cycle counters.
//  Drives the same datapath mux selects as the current multicycle datapath.
// PARAMETERS
//  CNT_W      32  width of cycle_cnt / instret_cnt (wrap mod 2^CNT_W)
//  EN_SHIFT   1   1: decode SLL/SRL/SRA (R and I forms); 0: these encodings trap
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset; one clock; reset is synchronous and active-low
//  Zero       in   1      ALU result == 0
//  SignBit    in   1      ALU result[31]
//  Op         in   7      instr[6:0]
//  F3         in   3      instr[14:12]
//  F7         in   7      instr[31:25]
//  mem_ready  in   1      memory completes the current access this cycle
//  MemReq     out  1      memory access request
//  MemWrite   out  1      store strobe (valid only with MemReq)
//  AdrSrc     out  1      0 PC, 1 ALUOut
//  IrWrite    out  1      load IR/OldPC
//  RegWrite   out  1      register-file write enable
//  PcEn       out  1      PC write enable
//  ImmSrc     out  3      0 I, 1 S, 2 B, 3 J, 4 U
//  AluSrcA    out  2      0 PC, 1 OldPC, 2 rs1
//  AluSrcB    out  2      0 rs2, 1 imm, 2 const 4
//  AluCtl     out  4      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA
//  ResultSrc  out  2      0 ALUOut, 1 MDR, 2 ALU, 3 {31'b0,SignBit}
//  RDS        out  2      rd data select: 0 Result, 1 imm (LUI), 2 Result (link)
//  illegal    out  1      high while in TRAP
//  cycle_cnt  out  CNT_W  cycles spent outside TRAP
//  instret_cnt out CNT_W  retired instructions
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=FETCH, both counters=0. All outputs are Moore/comb of state + inputs;
//   default 0 unless listed below.
//  FETCH: MemReq=1, AluSrcB=2, ResultSrc=2. Holds while mem_ready==0 (IrWrite=PcEn=0).
//   On mem_ready: IrWrite=1, PcEn=1, next DECODE.
//  DECODE: AluSrcA=1, AluSrcB=1, ImmSrc=2 (branch target to ALUOut). Next by Op:
//   R->EX_R, LW->EX_L, SW->EX_S, I-arith->EX_I, B->EX_B, LUI->WB_U, JAL/JALR->EX_J.
//   Any other Op -> TRAP.
//   R with F3/F7 not in {ADD,SUB,AND,OR,XOR,SLT}+shifts -> TRAP.
//   B with F3 not in {000,001,100,101} -> TRAP.
//   Shifts with EN_SHIFT=0 -> TRAP.
//  EX_R: AluSrcA=2, AluCtl=decoded (SLT->SUB). Next WB_R.
//  EX_I/EX_L/EX_S: AluSrcA=2, AluSrcB=1; ImmSrc=1 for EX_S; EX_I AluCtl=decoded.
//   Next WB_I/MEM_L/MEM_S respectively.
//  EX_B: AluSrcA=2, AluCtl=SUB, ResultSrc=0. PcEn = BEQ&Zero | BNE&~Zero | BLT&SignBit | BGE&~SignBit.
//   Next FETCH. PcEn from branch terms is asserted ONLY in EX_B.
//  EX_J: AluSrcA=1, AluSrcB=2 (OldPC+4 to ALUOut). Next WB_J.
//  MEM_L/MEM_S: MemReq=1, AdrSrc=1; MemWrite=1 in MEM_S. Hold until mem_ready.
//   Then MEM_L->WB_L, MEM_S->FETCH. MemWrite stays high for all wait cycles.
//  WB_R/WB_I: RegWrite=1, ResultSrc=3 if SLT/SLTI else 0.
//  WB_L: RegWrite=1, ResultSrc=1.
//  WB_U: RegWrite=1, ImmSrc=4, RDS=1.
//  WB_J: RegWrite=1, RDS=2, ResultSrc=2, PcEn=1, AluSrcB=1.
//   JAL: AluSrcA=1, ImmSrc=3. JALR: AluSrcA=2, ImmSrc=0.
//  All WB_* states -> FETCH.
//  TRAP: illegal=1, all other control outputs 0. Sticky until reset.
//  instret_cnt +1 on each cycle whose next state is FETCH and current state != FETCH.
//  cycle_cnt +1 every cycle not in TRAP. Both wrap silently.
//  mem_ready outside FETCH/MEM_L/MEM_S is ignored.
//  rst low mid-instruction: FETCH next edge; no write strobe in the reset cycle's following state.
// TESTING
//  ADD x3,x1,x2 with mem_ready=1 -> FETCH,DECODE,EX_R,WB_R; AluCtl=0 in EX_R;
//   RegWrite=1 one cycle; instret_cnt=1 after 4 cycles.
//  LW with mem_ready low 3 cycles in FETCH and 2 in MEM_L -> IrWrite/PcEn 1 cycle only,
//   AdrSrc=1 over 3 MEM_L cycles; total 10 cycles.
//  SW with mem_ready held low 5 cycles -> MemReq=MemWrite=1 for 6 cycles, then FETCH; RegWrite never 1.
//  BNE, Zero=0 in EX_B -> PcEn=1; BEQ, Zero=0 -> PcEn=0.
//   Zero toggling in any other non-FETCH state -> PcEn=0.
//  Op=7'b1111111 -> TRAP after DECODE, illegal=1, cycle_cnt frozen; rst=0 one edge -> FETCH, counters 0.
//  EN_SHIFT=0, SLL R-type -> TRAP; EN_SHIFT=1 -> AluCtl=5 in EX_R. CNT_W=4: 16 retired instrs -> instret_cnt=0.

Source files
------------

// File: rtl/mc_controller_hs.sv
// mc_controller_hs: multicycle RV32I control unit with a memory req/ready handshake,
// a sticky TRAP for illegal encodings, and cycle / retired-instruction counters.
module mc_controller_hs #(
  parameter int CNT_W    = 32,
  parameter bit EN_SHIFT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Zero,
  input  logic             SignBit,
  input  logic [6:0]       Op,
  input  logic [2:0]       F3,
  input  logic [6:0]       F7,
  input  logic             mem_ready,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IrWrite,
  output logic             RegWrite,
  output logic             PcEn,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [3:0]       AluCtl,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       RDS,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // state   | meaning
  // FETCH   | request instruction, wait for mem_ready, load IR and PC+4
  // DECODE  | classify opcode, precompute branch target into ALUOut
  // EX_R/I  | register / immediate ALU operation
  // EX_L/S  | load / store address calculation
  // EX_B    | compare rs1-rs2, conditionally load branch target into PC
  // EX_J    | OldPC+4 into ALUOut as the link value
  // MEM_L/S | data memory access, held until mem_ready
  // WB_*    | register write-back (WB_J also redirects PC)
  // TRAP    | illegal encoding, sticky until reset
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_EX_L, S_EX_S, S_EX_B, S_EX_J,
    S_MEM_L, S_MEM_S, S_WB_R, S_WB_I, S_WB_L, S_WB_U, S_WB_J, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  logic       w_op_r, w_op_i, w_op_l, w_op_s, w_op_b, w_op_lui, w_op_jal, w_op_jalr;
  logic       w_f7_zero, w_f7_alt, w_slt;
  logic       w_alu_legal, w_br_legal, w_br_take;
  logic [3:0] w_alu_ctl;

  assign w_op_r    = (Op == OP_R);
  assign w_op_i    = (Op == OP_I);
  assign w_op_l    = (Op == OP_L);
  assign w_op_s    = (Op == OP_S);
  assign w_op_b    = (Op == OP_B);
  assign w_op_lui  = (Op == OP_LUI);
  assign w_op_jal  = (Op == OP_JAL);
  assign w_op_jalr = (Op == OP_JALR);
  assign w_f7_zero = (F7 == 7'b0000000);
  assign w_f7_alt  = (F7 == 7'b0100000);
  assign w_slt     = (F3 == 3'b010);

  // Shared R/I-form decode; F7 only qualifies the immediate form for shifts.
  always_comb begin
    w_alu_legal = 1'b0;
    w_alu_ctl   = ALU_ADD;
    case (F3)
      3'b000: begin
        w_alu_legal = w_op_r ? (w_f7_zero | w_f7_alt) : 1'b1;
        w_alu_ctl   = (w_op_r && w_f7_alt) ? ALU_SUB : ALU_ADD;
      end
      3'b010: begin
        w_alu_legal = w_op_r ? w_f7_zero : 1'b1;
        w_alu_ctl   = ALU_SUB;
      end
      3'b100: begin
        w_alu_legal = w_op_r ? w_f7_zero : 1'b1;
        w_alu_ctl   = ALU_XOR;
      end
      3'b110: begin
        w_alu_legal = w_op_r ? w_f7_zero : 1'b1;
        w_alu_ctl   = ALU_OR;
      end
      3'b111: begin
        w_alu_legal = w_op_r ? w_f7_zero : 1'b1;
        w_alu_ctl   = ALU_AND;
      end
      3'b001: begin
        w_alu_legal = EN_SHIFT && w_f7_zero;
        w_alu_ctl   = ALU_SLL;
      end
      3'b101: begin
        w_alu_legal = EN_SHIFT && (w_f7_zero || w_f7_alt);
        w_alu_ctl   = w_f7_alt ? ALU_SRA : ALU_SRL;
      end
      default: begin
        w_alu_legal = 1'b0;
        w_alu_ctl   = ALU_ADD;
      end
    endcase
  end

  always_comb begin
    w_br_legal = 1'b1;
    w_br_take  = 1'b0;
    case (F3)
      3'b000:  w_br_take = Zero;
      3'b001:  w_br_take = ~Zero;
      3'b100:  w_br_take = SignBit;
      3'b101:  w_br_take = ~SignBit;
      default: w_br_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        w_next = S_TRAP;
        if (w_op_r && w_alu_legal)          w_next = S_EX_R;
        else if (w_op_i && w_alu_legal)     w_next = S_EX_I;
        else if (w_op_l)                    w_next = S_EX_L;
        else if (w_op_s)                    w_next = S_EX_S;
        else if (w_op_b && w_br_legal)      w_next = S_EX_B;
        else if (w_op_lui)                  w_next = S_WB_U;
        else if (w_op_jal || w_op_jalr)     w_next = S_EX_J;
      end
      S_EX_R:   w_next = S_WB_R;
      S_EX_I:   w_next = S_WB_I;
      S_EX_L:   w_next = S_MEM_L;
      S_EX_S:   w_next = S_MEM_S;
      S_EX_B:   w_next = S_FETCH;
      S_EX_J:   w_next = S_WB_J;
      S_MEM_L:  if (mem_ready) w_next = S_WB_L;
      S_MEM_S:  if (mem_ready) w_next = S_FETCH;
      S_WB_R, S_WB_I, S_WB_L, S_WB_U, S_WB_J: w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
  end

  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IrWrite   = 1'b0;
    RegWrite  = 1'b0;
    PcEn      = 1'b0;
    ImmSrc    = 3'd0;
    AluSrcA   = 2'd0;
    AluSrcB   = 2'd0;
    AluCtl    = ALU_ADD;
    ResultSrc = 2'd0;
    RDS       = 2'd0;
    illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemReq    = 1'b1;
        AluSrcB   = 2'd2;
        ResultSrc = 2'd2;
        IrWrite   = mem_ready;
        PcEn      = mem_ready;
      end
      S_DECODE: begin
        AluSrcA = 2'd1;
        AluSrcB = 2'd1;
        ImmSrc  = 3'd2;
      end
      S_EX_R: begin
        AluSrcA = 2'd2;
        AluCtl  = w_alu_ctl;
      end
      S_EX_I: begin
        AluSrcA = 2'd2;
        AluSrcB = 2'd1;
        AluCtl  = w_alu_ctl;
      end
      S_EX_L: begin
        AluSrcA = 2'd2;
        AluSrcB = 2'd1;
      end
      S_EX_S: begin
        AluSrcA = 2'd2;
        AluSrcB = 2'd1;
        ImmSrc  = 3'd1;
      end
      S_EX_B: begin
        AluSrcA = 2'd2;
        AluCtl  = ALU_SUB;
        PcEn    = w_br_take;
      end
      S_EX_J: begin
        AluSrcA = 2'd1;
        AluSrcB = 2'd2;
      end
      S_MEM_L: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEM_S: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_WB_R, S_WB_I: begin
        RegWrite  = 1'b1;
        ResultSrc = w_slt ? 2'd3 : 2'd0;
      end
      S_WB_L: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'd1;
      end
      S_WB_U: begin
        RegWrite = 1'b1;
        ImmSrc   = 3'd4;
        RDS      = 2'd1;
      end
      S_WB_J: begin
        RegWrite  = 1'b1;
        RDS       = 2'd2;
        ResultSrc = 2'd2;
        PcEn      = 1'b1;
        AluSrcB   = 2'd1;
        AluSrcA   = w_op_jalr ? 2'd2 : 2'd1;
        ImmSrc    = w_op_jalr ? 3'd0 : 3'd3;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  // An instruction retires on the cycle that hands control back to FETCH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_FETCH;
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != S_TRAP)
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_next == S_FETCH && r_state != S_FETCH)
        r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_mc_controller_hs.sv
// Directed bench for mc_controller_hs: a full-feature instance plus a
// shift-disabled, 4-bit-counter instance driven by the same stimulus.
module tb_mc_controller_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Zero = 1'b0;
  logic       SignBit = 1'b0;
  logic       mem_ready = 1'b0;
  logic [6:0] Op = 7'd0;
  logic [2:0] F3 = 3'd0;
  logic [6:0] F7 = 7'd0;

  logic        MemReq, MemWrite, AdrSrc, IrWrite, RegWrite, PcEn, illegal;
  logic [2:0]  ImmSrc;
  logic [1:0]  AluSrcA, AluSrcB, ResultSrc, RDS;
  logic [3:0]  AluCtl;
  logic [31:0] cycle_cnt, instret_cnt;

  logic        b_MemReq, b_MemWrite, b_AdrSrc, b_IrWrite, b_RegWrite, b_PcEn, b_illegal;
  logic [2:0]  b_ImmSrc;
  logic [1:0]  b_AluSrcA, b_AluSrcB, b_ResultSrc, b_RDS;
  logic [3:0]  b_AluCtl;
  logic [3:0]  b_cycle_cnt, b_instret_cnt;

  logic [21:0] ctl, b_ctl;
  int total = 0;
  int bad = 0;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  mc_controller_hs #(.CNT_W(32), .EN_SHIFT(1'b1)) dut (
    .clk(clk), .rst(rst), .Zero(Zero), .SignBit(SignBit), .Op(Op), .F3(F3), .F7(F7),
    .mem_ready(mem_ready), .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IrWrite(IrWrite), .RegWrite(RegWrite), .PcEn(PcEn), .ImmSrc(ImmSrc),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluCtl(AluCtl), .ResultSrc(ResultSrc),
    .RDS(RDS), .illegal(illegal), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  mc_controller_hs #(.CNT_W(4), .EN_SHIFT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .Zero(Zero), .SignBit(SignBit), .Op(Op), .F3(F3), .F7(F7),
    .mem_ready(mem_ready), .MemReq(b_MemReq), .MemWrite(b_MemWrite), .AdrSrc(b_AdrSrc),
    .IrWrite(b_IrWrite), .RegWrite(b_RegWrite), .PcEn(b_PcEn), .ImmSrc(b_ImmSrc),
    .AluSrcA(b_AluSrcA), .AluSrcB(b_AluSrcB), .AluCtl(b_AluCtl), .ResultSrc(b_ResultSrc),
    .RDS(b_RDS), .illegal(b_illegal), .cycle_cnt(b_cycle_cnt), .instret_cnt(b_instret_cnt)
  );

  assign ctl   = {MemReq, MemWrite, AdrSrc, IrWrite, RegWrite, PcEn, ImmSrc,
                  AluSrcA, AluSrcB, AluCtl, ResultSrc, RDS, illegal};
  assign b_ctl = {b_MemReq, b_MemWrite, b_AdrSrc, b_IrWrite, b_RegWrite, b_PcEn, b_ImmSrc,
                  b_AluSrcA, b_AluSrcB, b_AluCtl, b_ResultSrc, b_RDS, b_illegal};

  always #5 clk = ~clk;

  function automatic logic [21:0] pk(input int mr, mw, adr, irw, rw, pc, imm,
                                     asa, asb, alu, rs, rds, ill);
    return {1'(mr), 1'(mw), 1'(adr), 1'(irw), 1'(rw), 1'(pc), 3'(imm),
            2'(asa), 2'(asb), 4'(alu), 2'(rs), 2'(rds), 1'(ill)};
  endfunction

  logic [21:0] P_FW, P_FR, P_DEC, P_EXR0, P_EXR1, P_EXR5, P_WBR0, P_WBR3, P_EXI4, P_EXL;
  logic [21:0] P_MEML, P_WBL, P_EXS, P_MEMS, P_EXB0, P_EXB1, P_EXJ, P_WBJAL, P_WBJALR;
  logic [21:0] P_WBU, P_TRAP;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [21:0] exp);
    total++;
    assert (ctl === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, ctl, exp);
    end
  endtask

  task automatic chk_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [21:0] exp);
    #1;
    chk_ctl(tag, exp);
    tick();
  endtask

  task automatic fetch(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7);
    Op = op; F3 = f3; F7 = f7;
    mem_ready = 1'b1;
    cyc({tag, "_fetch"}, P_FR);
    mem_ready = 1'b0;
    cyc({tag, "_decode"}, P_DEC);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    //          mr mw ad ir rw pc im sa sb alu rs rd il
    P_FW     = pk(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0);
    P_FR     = pk(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, 2, 0, 0);
    P_DEC    = pk(0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    P_EXR0   = pk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    P_EXR1   = pk(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
    P_EXR5   = pk(0, 0, 0, 0, 0, 0, 0, 2, 0, 5, 0, 0, 0);
    P_WBR0   = pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    P_WBR3   = pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0);
    P_EXI4   = pk(0, 0, 0, 0, 0, 0, 0, 2, 1, 4, 0, 0, 0);
    P_EXL    = pk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    P_MEML   = pk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    P_WBL    = pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    P_EXS    = pk(0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0);
    P_MEMS   = pk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    P_EXB0   = pk(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
    P_EXB1   = pk(0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0, 0, 0);
    P_EXJ    = pk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    P_WBJAL  = pk(0, 0, 0, 0, 1, 1, 3, 1, 1, 0, 2, 2, 0);
    P_WBJALR = pk(0, 0, 0, 0, 1, 1, 0, 2, 1, 0, 2, 2, 0);
    P_WBU    = pk(0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0, 1, 0);
    P_TRAP   = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    do_reset();
    #1 chk_ctl("rst_fetch", P_FW);
    chk_n("rst_cycle", cycle_cnt, 0);
    chk_n("rst_instret", instret_cnt, 0);

    // ADD x3,x1,x2; Zero toggles in WB_R must not move the PC
    fetch("add", OP_R, 3'b000, 7'd0);
    cyc("add_exr", P_EXR0);
    Zero = 1'b1;
    cyc("add_wbr", P_WBR0);
    Zero = 1'b0;
    chk_n("add_instret", instret_cnt, 1);
    chk_n("add_cycle", cycle_cnt, 4);

    // LW: 3 fetch waits, 2 MEM_L waits, 10 cycles total
    Op = OP_L; F3 = 3'b010; F7 = 7'd0; mem_ready = 1'b0;
    repeat (3) cyc("lw_fetch_wait", P_FW);
    fetch("lw", OP_L, 3'b010, 7'd0);
    mem_ready = 1'b1;
    cyc("lw_exl_ready_ignored", P_EXL);
    mem_ready = 1'b0;
    repeat (2) cyc("lw_meml_wait", P_MEML);
    mem_ready = 1'b1;
    cyc("lw_meml_ready", P_MEML);
    mem_ready = 1'b0;
    cyc("lw_wbl", P_WBL);
    chk_n("lw_instret", instret_cnt, 2);
    chk_n("lw_cycle", cycle_cnt, 14);

    // SW with 5 wait cycles: MemWrite held 6 cycles
    fetch("sw", OP_S, 3'b010, 7'd0);
    cyc("sw_exs", P_EXS);
    repeat (5) cyc("sw_mems_wait", P_MEMS);
    mem_ready = 1'b1;
    cyc("sw_mems_ready", P_MEMS);
    mem_ready = 1'b0;
    #1 chk_ctl("sw_back_fetch", P_FW);
    chk_n("sw_instret", instret_cnt, 3);
    chk_n("sw_cycle", cycle_cnt, 23);

    // branches
    fetch("bne", OP_B, 3'b001, 7'd0);
    Zero = 1'b1;
    #1 chk_ctl("bne_zero1", P_EXB0);
    Zero = 1'b0;
    cyc("bne_zero0", P_EXB1);
    fetch("beq", OP_B, 3'b000, 7'd0);
    cyc("beq_zero0", P_EXB0);
    fetch("blt", OP_B, 3'b100, 7'd0);
    SignBit = 1'b1;
    cyc("blt_sign1", P_EXB1);
    SignBit = 1'b0;
    chk_n("br_instret", instret_cnt, 6);
    chk_n("br_cycle", cycle_cnt, 32);

    // SLL: executes on the main instance, traps on the shift-disabled one
    fetch("sll", OP_R, 3'b001, 7'd0);
    #1 chk_n("b_sll_trap", 32'(b_illegal), 1);
    cyc("sll_exr", P_EXR5);
    cyc("sll_wbr", P_WBR0);
    chk_n("b_trap_cycle", 32'(b_cycle_cnt), 2);
    chk_n("b_trap_instret", 32'(b_instret_cnt), 6);
    total++;
    assert (b_ctl === P_TRAP) else begin
      bad++;
      $error("FAIL b_trap_ctl observed=%h expected=%h", b_ctl, P_TRAP);
    end

    fetch("slt", OP_R, 3'b010, 7'd0);
    cyc("slt_exr", P_EXR1);
    cyc("slt_wbr", P_WBR3);
    fetch("xori", OP_I, 3'b100, 7'd0);
    cyc("xori_exi", P_EXI4);
    cyc("xori_wbi", P_WBR0);
    fetch("lui", OP_LUI, 3'b000, 7'd0);
    cyc("lui_wbu", P_WBU);
    fetch("jal", OP_JAL, 3'b000, 7'd0);
    cyc("jal_exj", P_EXJ);
    cyc("jal_wbj", P_WBJAL);
    fetch("jalr", OP_JALR, 3'b000, 7'd0);
    cyc("jalr_exj", P_EXJ);
    cyc("jalr_wbj", P_WBJALR);
    chk_n("mix_instret", instret_cnt, 12);
    chk_n("mix_cycle", cycle_cnt, 55);
    chk_n("b_frozen_cycle", 32'(b_cycle_cnt), 2);

    // illegal opcode: sticky trap, cycle count frozen
    fetch("ill", 7'b1111111, 3'b000, 7'd0);
    mem_ready = 1'b1;
    cyc("trap1", P_TRAP);
    cyc("trap2", P_TRAP);
    chk_n("trap_cycle", cycle_cnt, 57);
    chk_n("trap_instret", instret_cnt, 12);
    mem_ready = 1'b0;
    do_reset();
    #1 chk_ctl("trap_rst_fetch", P_FW);
    chk_n("trap_rst_cycle", cycle_cnt, 0);
    chk_n("trap_rst_instret", instret_cnt, 0);

    // branch with unsupported funct3
    fetch("bill", OP_B, 3'b010, 7'd0);
    cyc("bill_trap", P_TRAP);
    do_reset();

    // 16 LUIs wrap the 4-bit counters of the second instance
    for (int i = 0; i < 16; i++) begin
      fetch("luiw", OP_LUI, 3'b000, 7'd0);
      cyc("luiw_wbu", P_WBU);
      if (i == 14) chk_n("b_instret_15", 32'(b_instret_cnt), 15);
    end
    chk_n("luiw_instret", instret_cnt, 16);
    chk_n("luiw_cycle", cycle_cnt, 48);
    chk_n("b_instret_wrap", 32'(b_instret_cnt), 0);
    chk_n("b_cycle_wrap", 32'(b_cycle_cnt), 0);

    // reset in the middle of a store
    fetch("swr", OP_S, 3'b010, 7'd0);
    cyc("swr_exs", P_EXS);
    #1 chk_ctl("swr_mems", P_MEMS);
    do_reset();
    #1 chk_ctl("swr_rst_fetch", P_FW);
    chk_n("swr_rst_cycle", cycle_cnt, 0);
    chk_n("swr_rst_instret", instret_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
